// File: rtl/fpu_driver.sv
// Sequences operand pairs from an 8-entry table into an external FPU, waits a fixed number
// of cycles, captures each result/status and hands it to a consumer with a valid/ready handshake.
module fpu_driver #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_A,
  input  logic [31:0] wr_B,
  input  logic [3:0]  num_ops,
  input  logic        start,
  output logic [31:0] op_A_out,
  output logic [31:0] op_B_out,
  input  logic [31:0] fpu_data_in,
  input  logic [3:0]  fpu_status_in,
  output logic [31:0] result_out,
  output logic [3:0]  status_cap,
  output logic [2:0]  result_idx,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        done,
  output logic [3:0]  flag_count
);

  typedef enum logic [1:0] {StIdle, StPresent, StHold, StDone} state_e;

  state_e      state_q;
  logic [63:0] table_q [8];
  logic [2:0]  idx_q;
  logic [2:0]  last_q;
  logic [3:0]  cnt_q;
  logic [31:0] op_a_q, op_b_q, result_q;
  logic [3:0]  status_q, flag_q;
  logic [2:0]  result_idx_q;
  logic        valid_q, busy_q, done_q;

  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      for (int i = 0; i < 8; i++) table_q[i] <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      status_q     <= '0;
      result_idx_q <= '0;
      flag_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_en) table_q[wr_addr] <= {wr_A, wr_B};
          if (start) begin
            flag_q <= '0;
            idx_q  <= '0;
            if (num_ops == 4'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StPresent;
              busy_q  <= 1'b1;
              last_q  <= (num_ops > 4'd8) ? 3'd7 : 3'(num_ops - 4'd1);
              cnt_q   <= 4'(WAIT_CYCLES);
              op_a_q  <= table_q[0][63:32];
              op_b_q  <= table_q[0][31:0];
            end
          end
        end
        StPresent: begin
          if (cnt_q == 4'd0) begin
            result_q     <= fpu_data_in;
            status_q     <= fpu_status_in;
            result_idx_q <= idx_q;
            valid_q      <= 1'b1;
            if (fpu_status_in != 4'd0 && flag_q != 4'hF) flag_q <= flag_q + 4'd1;
            state_q      <= StHold;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StHold: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            if (idx_q == last_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Operands switch only after the consumer has taken the previous result.
              idx_q   <= idx_q + 3'd1;
              op_a_q  <= table_q[3'(idx_q + 3'd1)][63:32];
              op_b_q  <= table_q[3'(idx_q + 3'd1)][31:0];
              cnt_q   <= 4'(WAIT_CYCLES);
              state_q <= StPresent;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign op_A_out     = op_a_q;
  assign op_B_out     = op_b_q;
  assign result_out   = result_q;
  assign status_cap   = status_q;
  assign result_idx   = result_idx_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign flag_count   = flag_q;

endmodule

// File: tb/tb_fpu_driver.sv
// Bench for fpu_driver: table of operand/result vectors, scoreboard queue popped on each
// capture, plus directed sequences for handshake stall, empty run, mid-run noise and reset.
module tb_fpu_driver;
  localparam int unsigned W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_A, wr_B;
  logic [3:0]  num_ops;
  logic        start;
  logic [31:0] op_A_out, op_B_out;
  logic [31:0] fpu_data;
  logic [3:0]  fpu_status;
  logic [31:0] result_out;
  logic [3:0]  status_cap;
  logic [2:0]  result_idx;
  logic        result_valid, result_ready, busy, done;
  logic [3:0]  flag_count;

  always #5 clk = ~clk;

  fpu_driver #(.WAIT_CYCLES(W)) dut (
    .clock100KHz  (clk),
    .reset        (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_A         (wr_A),
    .wr_B         (wr_B),
    .num_ops      (num_ops),
    .start        (start),
    .op_A_out     (op_A_out),
    .op_B_out     (op_B_out),
    .fpu_data_in  (fpu_data),
    .fpu_status_in(fpu_status),
    .result_out   (result_out),
    .status_cap   (status_cap),
    .result_idx   (result_idx),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done),
    .flag_count   (flag_count)
  );

  // Stand-in FPU: 1.0 + 2.0 gives 3.0, otherwise an integer sum; status is A's low nibble.
  always_comb begin
    if (op_A_out == 32'h3F800000 && op_B_out == 32'h40000000) fpu_data = 32'h40400000;
    else fpu_data = op_A_out + op_B_out;
    fpu_status = op_A_out[3:0];
  end

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] data; logic [3:0] st; } vec_t;
  typedef struct { logic [31:0] data; logic [3:0] st; logic [2:0] idx; } exp_t;

  vec_t vecs [8];
  exp_t sb [$];
  exp_t mon_e;
  int   caps [$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, done_cnt = 0, start_edge = 0;
  logic rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      caps.push_back(cyc);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_capture: got idx %0d, expected no capture", result_idx);
      end else begin
        mon_e = sb.pop_front();
        chk("result_out", 64'(result_out), 64'(mon_e.data));
        chk("status_cap", 64'(status_cap), 64'(mon_e.st));
        chk("result_idx", 64'(result_idx), 64'(mon_e.idx));
      end
    end
    rv_prev <= result_valid;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_op_A"}, 64'(op_A_out), 64'd0);
    chk({tag, "_op_B"}, 64'(op_B_out), 64'd0);
    chk({tag, "_result"}, 64'(result_out), 64'd0);
    chk({tag, "_status"}, 64'(status_cap), 64'd0);
    chk({tag, "_idx"}, 64'(result_idx), 64'd0);
    chk({tag, "_valid"}, 64'(result_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_flags"}, 64'(flag_count), 64'd0);
  endtask

  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{vecs[i].data, vecs[i].st, 3'(i)});
  endtask

  task automatic do_start(input logic [3:0] n);
    @(negedge clk);
    num_ops = n;
    start   = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    start_edge = cyc;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: done not seen, expected within 200 cycles", name);
    end
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!result_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!result_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: result_valid not seen, expected within 100 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    int   d0, k;
    logic stable;
    logic [31:0] r_snap, a_snap;
    logic [3:0]  s_snap;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_A = '0; wr_B = '0;
    num_ops = '0; start = 1'b0; result_ready = 1'b0;
    vecs[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 4'h0};
    vecs[1] = '{32'h00000012, 32'h00000100, 32'h00000112, 4'h2};
    vecs[2] = '{32'h00000022, 32'h00000200, 32'h00000222, 4'h2};
    vecs[3] = '{32'h11110000, 32'h22220000, 32'h33330000, 4'h0};
    vecs[4] = '{32'h0000000F, 32'h00000001, 32'h00000010, 4'hF};
    vecs[5] = '{32'h12345670, 32'h01010101, 32'h13355771, 4'h0};
    vecs[6] = '{32'h00000005, 32'hFFFFFFFF, 32'h00000004, 4'h5};
    vecs[7] = '{32'hA0000000, 32'h60000000, 32'h00000000, 4'h0};
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'(i); wr_A = vecs[i].a; wr_B = vecs[i].b;
    end
    @(negedge clk);
    wr_en = 1'b0;

    // Single op: latency, accept, done.
    result_ready = 1'b0;
    push_run(1);
    caps.delete();
    do_start(4'd1);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_valid("single_valid");
    chk("single_latency", 64'(cyc - start_edge), 64'(W + 1));
    result_ready = 1'b1;
    @(negedge clk);
    chk("single_done", 64'(done), 64'd1);
    chk("single_busy", 64'(busy), 64'd0);
    chk("single_valid_clr", 64'(result_valid), 64'd0);
    chk("single_flags", 64'(flag_count), 64'd0);
    chk("single_sb_empty", 64'(sb.size()), 64'd0);

    // num_ops=9 clamps to a full 8-entry run, back-to-back accepts.
    repeat (3) @(negedge clk);
    push_run(8);
    caps.delete();
    d0 = done_cnt;
    do_start(4'd9);
    wait_done("full_run");
    chk("full_flags", 64'(flag_count), 64'd4);
    @(negedge clk);
    chk("full_captures", 64'(caps.size()), 64'd8);
    if (caps.size() == 8) begin
      chk("full_first_latency", 64'(caps[0] - start_edge), 64'(W + 1));
      for (int i = 1; i < 8; i++) chk("full_spacing", 64'(caps[i] - caps[i-1]), 64'(W + 2));
    end
    chk("full_done_count", 64'(done_cnt - d0), 64'd1);
    chk("full_op_hold", 64'(op_A_out), 64'(vecs[7].a));

    // Consumer stall in HOLD for 10 cycles.
    repeat (3) @(negedge clk);
    result_ready = 1'b0;
    push_run(2);
    caps.delete();
    do_start(4'd2);
    wait_valid("stall_valid");
    r_snap = result_out; s_snap = status_cap; a_snap = op_A_out;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!result_valid || result_out != r_snap || status_cap != s_snap || op_A_out != a_snap)
        stable = 1'b0;
    end
    chk("stall_stable", 64'(stable), 64'd1);
    chk("stall_one_capture", 64'(caps.size()), 64'd1);
    result_ready = 1'b1;
    wait_done("stall_run");
    @(negedge clk);
    chk("stall_captures", 64'(caps.size()), 64'd2);

    // Empty run.
    repeat (3) @(negedge clk);
    caps.delete();
    do_start(4'd0);
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("empty_done_pulse", 64'(done), 64'd0);
    repeat (5) @(negedge clk);
    chk("empty_no_capture", 64'(caps.size()), 64'd0);

    // 4-entry run with start and a table write poked mid-run.
    push_run(4);
    caps.delete();
    d0 = done_cnt;
    do_start(4'd4);
    repeat (8) @(negedge clk);
    start = 1'b1; num_ops = 4'd1;
    wr_en = 1'b1; wr_addr = 3'd3; wr_A = 32'hDEAD0003; wr_B = 32'h0;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; num_ops = 4'd4;
    wait_done("noise_run");
    chk("noise_flags_done", 64'(flag_count), 64'd2);
    repeat (2) @(negedge clk);
    chk("noise_done_count", 64'(done_cnt - d0), 64'd1);
    chk("noise_captures", 64'(caps.size()), 64'd4);
    chk("noise_flags_hold", 64'(flag_count), 64'd2);
    chk("noise_op_hold", 64'(op_A_out), 64'(vecs[3].a));

    // Reset in PRESENT of entry 1.
    push_run(2);
    caps.delete();
    d0 = done_cnt;
    do_start(4'd2);
    k = 0;
    while (caps.size() < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("pre_reset_idx1", 64'(op_A_out), 64'(vecs[1].a));
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(result_valid), 64'd0);
    chk("abort_captures", 64'(caps.size()), 64'd1);

    // Table must read back as zeros.
    sb.push_back('{32'h0, 4'h0, 3'd0});
    sb.push_back('{32'h0, 4'h0, 3'd1});
    caps.delete();
    do_start(4'd2);
    wait_done("zero_run");
    @(negedge clk);
    chk("zero_captures", 64'(caps.size()), 64'd2);
    chk("zero_op_A", 64'(op_A_out), 64'd0);
    chk("zero_op_B", 64'(op_B_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_driver.md
FPU_DRIVER -- requirements
Module: fpu_driver

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, default 4, number of clock cycles operands are held before the FPU result is sampled (legal range 1..15).
REQ-002 SHALL have port: clock100KHz  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: wr_en  input  1  operand-table write strobe.
REQ-005 SHALL have port: wr_addr  input  3  operand-table entry index.
REQ-006 SHALL have port: wr_A  input  32  operand A value to store.
REQ-007 SHALL have port: wr_B  input  32  operand B value to store.
REQ-008 SHALL have port: num_ops  input  4  number of table entries to run, starting at entry 0.
REQ-009 SHALL have port: start  input  1  single-cycle run request.
REQ-010 SHALL have port: op_A_out  output  32  operand A driven to the FPU op_A_in.
REQ-011 SHALL have port: op_B_out  output  32  operand B driven to the FPU op_B_in.
REQ-012 SHALL have port: fpu_data_in  input  32  FPU data_out.
REQ-013 SHALL have port: fpu_status_in  input  4  FPU status_out; treated as opaque bits.
REQ-014 SHALL have port: result_out  output  32  captured FPU result.
REQ-015 SHALL have port: status_cap  output  4  captured FPU status.
REQ-016 SHALL have port: result_idx  output  3  table index of the captured result.
REQ-017 SHALL have port: result_valid  output  1  captured result available.
REQ-018 SHALL have port: result_ready  input  1  consumer accepts the result.
REQ-019 SHALL have port: busy  output  1  run in progress.
REQ-020 SHALL have port: done  output  1  one-cycle pulse at the end of a run.
REQ-021 SHALL have port: flag_count  output  4  count of results in the current run with nonzero status, saturating at 15.

Function
REQ-022 SHALL hold an 8-entry x 64-bit operand table; on wr_en in IDLE, entry wr_addr is written with {wr_A, wr_B}; wr_en outside IDLE is ignored.
REQ-023 SHALL implement FSM states IDLE, PRESENT, HOLD, DONE.
REQ-024 IDLE: start=1 with num_ops in 1..8 SHALL go to PRESENT, clear index and flag_count, and set busy on the same edge.
REQ-025 IDLE: start=1 with num_ops=0 SHALL go to DONE without presenting operands; num_ops>8 SHALL be clamped to 8.
REQ-026 PRESENT: op_A_out/op_B_out SHALL equal table[index] and remain stable; a wait counter loaded with WAIT_CYCLES SHALL decrement each cycle.
REQ-027 PRESENT: on the edge where the counter reaches 0, the block SHALL capture fpu_data_in, fpu_status_in, and index into result_out, status_cap, and result_idx, set result_valid, and go to HOLD.
REQ-028 Latency: the first capture SHALL occur WAIT_CYCLES+1 rising edges after the edge that sampled start.
REQ-029 HOLD: result_valid and the captured values SHALL remain stable until result_valid && result_ready is sampled high.
REQ-030 HOLD, on accept: the block SHALL clear result_valid, and SHALL either increment the index and return to PRESENT if more entries remain, or go to DONE.
REQ-031 With result_ready held at 1, consecutive captures SHALL be exactly WAIT_CYCLES+2 cycles apart.
REQ-032 On capture with status != 0, flag_count SHALL increment, saturating at 15.
REQ-033 DONE: done=1 and busy=0 SHALL be driven for one cycle, after which the FSM goes to IDLE; flag_count SHALL hold until the next start.
REQ-034 start outside IDLE SHALL be ignored.
REQ-035 During a run, op_A_out/op_B_out SHALL hold the last presented entry while in HOLD, DONE, and IDLE.

Reset
REQ-036 reset=1 SHALL immediately set the FSM to IDLE and force all outputs to 0: op_A_out, op_B_out, result_out, status_cap, result_idx, result_valid, busy, done, flag_count.
REQ-037 reset SHALL clear the operand table to all zeros.
REQ-038 reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL require a new start.

Verification
REQ-039 Scenario: load entry0 = (0x3F800000, 0x40000000), num_ops=1, start, FPU model returns 0x40400000 with status 0 -> result_valid rises 5 edges after start (WAIT_CYCLES=4), result_out=0x40400000, result_idx=0, done pulses after accept, flag_count=0.
REQ-040 Scenario: num_ops=3, result_ready tied to 1 -> exactly 3 captures, 6 cycles apart, with result_idx 0, 1, 2, followed by one done pulse.
REQ-041 Scenario: result_ready held at 0 for 10 cycles during HOLD -> result_valid, result_out, status_cap, and op_A_out stay constant; the next entry starts only after accept.
REQ-042 Scenario: num_ops=0 plus start -> done pulses 1 cycle later; result_valid is never asserted.
REQ-043 Scenario: FPU status 0x2 on entries 1 and 2 of a 4-entry run -> flag_count=2 at done; start and wr_en pulsed mid-run have no effect.
REQ-044 Scenario: reset pulsed in PRESENT of entry 1 -> all outputs read 0 asynchronously, the table reads back as 0, there is no done pulse, and the block stays idle until start.
